frame_load_ctrl: RTL
====================

// Module: frame_load_ctrl
// PURPOSE
//  Sequences reception of one image frame from the UART receiver into the frame RAM.
//  - Waits for a sync byte, then writes NUM_PIX pixel bytes to consecutive RAM addresses.
//  - Pulses pixel_received once per stored pixel, for the count_pixels checker.
//  - Flags frame completion, UART errors and stream stalls.
//  - Sits between uart_rx and the frame RAM / display path.
// PARAMETERS
//  NUM_PIX      400     pixels per frame (>=2)
//  ADDR_W       9       RAM address width; 2**ADDR_W >= NUM_PIX
//  SYNC_BYTE    8'hAA   frame header byte
//  TIMEOUT_CYC  50000   idle cycles allowed between bytes in SYNC/LOAD (>=2)
// PORTS
//  clk             in   1       system clock, rising edge
//  reset           in   1       synchronous, active-high
//  start           in   1       1-cycle pulse: arm for a new frame
//  rx_data         in   8       received byte from uart_rx
//  rx_valid        in   1       1-cycle strobe: rx_data valid
//  rx_err          in   1       1-cycle strobe: framing error on current byte
//  wr_en           out  1       frame RAM write strobe
//  wr_addr         out  ADDR_W  frame RAM write address
//  wr_data         out  8       frame RAM write data
//  pixel_received  out  1       1-cycle pulse per pixel stored
//  busy            out  1       high in SYNC or LOAD
//  frame_done      out  1       level; high in DONE
//  err             out  1       level; high in ERR
//  err_code        out  1       0 = timeout, 1 = rx_err; valid while err=1
// BEHAVIOUR
//  Reset
//  - All outputs 0; state IDLE; pixel counter 0; watchdog 0.
//  - reset mid-frame aborts; no further writes occur.
//  States: IDLE, SYNC, LOAD, DONE, ERR. All outputs are registered.
//  IDLE
//  - start -> SYNC.
//  - rx_valid bytes are ignored.
//  - start coincident with rx_valid: go to SYNC; that byte is not used as sync.
//  SYNC
//  - rx_valid with rx_data==SYNC_BYTE -> LOAD, counter=0.
//  - Other bytes are discarded.
//  LOAD, rx_valid
//  - Next cycle: wr_en=1, wr_addr=counter, wr_data=rx_data, pixel_received=1 (latency 1).
//  - Counter increments.
//  - The byte written at counter==NUM_PIX-1 -> DONE.
//  - Byte equal to SYNC_BYTE in LOAD is pixel data, not resync.
//  DONE
//  - frame_done=1 and holds.
//  - Further rx bytes are ignored; no writes.
//  - start -> SYNC and clears frame_done.
//  rx_err
//  - rx_err in SYNC or LOAD -> ERR, err_code=1.
//  - The byte flagged by rx_err is not written.
//  - rx_err takes priority over rx_valid in the same cycle.
//  Watchdog
//  - Counts cycles in SYNC/LOAD since entry or last rx_valid.
//  - Reaching TIMEOUT_CYC -> ERR, err_code=0.
//  - rx_valid in the same cycle as expiry wins: it is processed and the watchdog is cleared.
//  ERR
//  - err=1 holds; no writes.
//  - start -> SYNC, clears err and err_code.
//  Other rules
//  - start in SYNC/LOAD is ignored; no restart mid-frame.
//  - The counter never wraps; exactly NUM_PIX writes per frame.
//  - Single-cycle pulses: wr_en, pixel_received. Levels: busy, frame_done, err.
// STRUCTURE
//  - Shared header uart_img_defs.vh: state encodings, SYNC_BYTE default, err_code values.
//  - One sub-module: rx_watchdog.
//    - Ports: clk, reset, run, kick -> expired.
//    - Parameter: TIMEOUT_CYC.
//  - FSM, pixel counter and write-port registers stay in frame_load_ctrl.
// TESTING
//  1. Reset, start, 0xAA, 400 bytes i[7:0]
//     -> 400 wr_en pulses, addr 0..399, data i[7:0], 400 pixel_received, frame_done=1.
//  2. start, bytes 0x11,0x22 then 0xAA, 0x55
//     -> pre-sync bytes produce no writes; first write addr 0, data 0x55.
//  3. TIMEOUT_CYC=100, start, 0xAA, 10 bytes then silence
//     -> err=1, err_code=0 exactly 100 cycles after last rx_valid; 10 writes.
//  4. rx_err with 5th pixel byte -> ERR, err_code=1, 4 writes only; start -> busy=1, err=0.
//  5. Reset asserted after 200 pixels
//     -> all outputs 0 next cycle; new start+0xAA restarts at addr 0.
//  6. Bytes after DONE and start during LOAD
//     -> no extra writes; frame still completes at 400.

Source files
------------

// File: rtl/frame_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frame_load_ctrl_pkg
//   Shared definitions for the frame loader: FSM state encoding, the default
//   frame header byte and the err_code values reported to the host.
// -----------------------------------------------------------------------------
package frame_load_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_LOAD = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

   localparam logic ERR_CODE_TIMEOUT = 1'b0;
   localparam logic ERR_CODE_RX_ERR  = 1'b1;

   // States in which a frame is in flight (busy, watchdog armed).
   function automatic logic is_busy(input state_t s);
      return (s == ST_SYNC) || (s == ST_LOAD);
   endfunction

endpackage

// File: rtl/frame_load_ctrl_rx_watchdog.sv
// -----------------------------------------------------------------------------
// frame_load_ctrl_rx_watchdog
//   Idle-cycle watchdog for the receive stream. Counts cycles while run is
//   high; kick (a received byte) or run low clears the count. expired is
//   asserted in the cycle in which TIMEOUT_CYC idle cycles have elapsed, so a
//   consumer registering on it reacts exactly TIMEOUT_CYC cycles after the
//   last kick / entry into run.
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high
//   run      in   watchdog armed
//   kick     in   clear the idle count (byte received)
//   expired  out  idle limit reached this cycle (suppressed by kick)
// -----------------------------------------------------------------------------
module frame_load_ctrl_rx_watchdog #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic kick,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   // Saturates at LAST; the controller leaves the busy states on expiry,
   // which drops run and clears the count.
   always_ff @(posedge clk) begin
      if (reset || !run || kick) begin
         cnt <= '0;
      end else if (cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

   // A byte arriving in the expiry cycle wins.
   assign expired = run && !kick && (cnt == LAST);

endmodule

// File: rtl/frame_load_ctrl.sv
// -----------------------------------------------------------------------------
// frame_load_ctrl
//   Sequences reception of one image frame from the UART receiver into the
//   frame RAM: waits for the header byte, then writes NUM_PIX pixel bytes to
//   consecutive addresses. Reports completion, receive errors and stalls.
// Ports
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high
//   start           in   1-cycle pulse, arm for a new frame
//   rx_data         in   received byte
//   rx_valid        in   1-cycle strobe, rx_data valid
//   rx_err          in   1-cycle strobe, framing error on current byte
//   wr_en           out  frame RAM write strobe
//   wr_addr         out  frame RAM write address
//   wr_data         out  frame RAM write data
//   pixel_received  out  1-cycle pulse per stored pixel
//   busy            out  level, frame in flight (SYNC or LOAD)
//   frame_done      out  level, frame complete
//   err             out  level, frame aborted
//   err_code        out  0 = timeout, 1 = rx_err; valid while err=1
// -----------------------------------------------------------------------------
module frame_load_ctrl
   import frame_load_ctrl_pkg::*;
#(
   parameter int         NUM_PIX     = 400,
   parameter int         ADDR_W      = 9,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              rx_err,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              pixel_received,
   output logic              busy,
   output logic              frame_done,
   output logic              err,
   output logic              err_code
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              wr_en_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [7:0]        wr_data_nxt;
   logic              err_code_nxt;
   logic              wd_run;
   logic              wd_expired;

   assign wd_run = is_busy(state);

   frame_load_ctrl_rx_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .run    (wd_run),
      .kick   (rx_valid),
      .expired(wd_expired)
   );

   // Next-state and next-output logic. Priority in SYNC/LOAD is
   // rx_err > rx_valid > watchdog expiry.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      wr_en_nxt    = 1'b0;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      err_code_nxt = err_code;

      unique case (state)
         ST_IDLE: begin
            // A byte arriving with start is never taken as the header.
            if (start) state_nxt = ST_SYNC;
         end
         ST_SYNC: begin
            if (rx_err) begin
               state_nxt    = ST_ERR;
               err_code_nxt = ERR_CODE_RX_ERR;
            end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_nxt = ST_LOAD;
               cnt_nxt   = '0;
            end else if (wd_expired) begin
               state_nxt    = ST_ERR;
               err_code_nxt = ERR_CODE_TIMEOUT;
            end
         end
         ST_LOAD: begin
            if (rx_err) begin
               state_nxt    = ST_ERR;
               err_code_nxt = ERR_CODE_RX_ERR;
            end else if (rx_valid) begin
               // Header-valued bytes here are ordinary pixel data.
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = cnt;
               wr_data_nxt = rx_data;
               if (cnt == LAST_ADDR) state_nxt = ST_DONE;
               else                  cnt_nxt   = cnt + 1'b1;
            end else if (wd_expired) begin
               state_nxt    = ST_ERR;
               err_code_nxt = ERR_CODE_TIMEOUT;
            end
         end
         ST_DONE, ST_ERR: begin
            if (start) begin
               state_nxt    = ST_SYNC;
               err_code_nxt = 1'b0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered state and outputs; status levels are decoded from the
   // next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         pixel_received <= 1'b0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         err            <= 1'b0;
         err_code       <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         wr_en          <= wr_en_nxt;
         wr_addr        <= wr_addr_nxt;
         wr_data        <= wr_data_nxt;
         pixel_received <= wr_en_nxt;
         busy           <= is_busy(state_nxt);
         frame_done     <= (state_nxt == ST_DONE);
         err            <= (state_nxt == ST_ERR);
         err_code       <= err_code_nxt;
      end
   end

endmodule
